// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch front end.
// The buffer entry pairs each instruction word with the PC it was fetched from.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch step; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Circular FIFO holding {pc, instruction} pairs between the BRAM response and the queue.
// Flush empties the FIFO in one cycle and takes priority over push and pop.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush_in,
  input  logic                push_in,
  input  logic [2*XLEN-1:0]   push_data_in,
  input  logic                pop_in,
  output logic [2*XLEN-1:0]   head_out,
  output logic [CNT_W-1:0]    count_out,
  output logic                empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign pop_ok = pop_in && (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_in) begin
        mem_d[tail_q] = push_data_in;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop_ok) begin
        head_d = ptr_inc(head_q);
      end
      if (push_in && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_in && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only visible through count_q.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign head_out  = mem_q[head_q];
  assign count_out = count_q;
  assign empty_out = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues sequential BRAM reads, realigns fixed-latency responses with
// their PCs, buffers them and hands them to the instruction queue; redirect squashes all.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              BRAM_LATENCY = 2,
  parameter int              BUF_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [31:0] bram_addr_out,
  output logic        bram_en_out,
  input  logic [31:0] bram_data_in,
  input  logic        iq_ready_in,
  output logic        iq_valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = $clog2(BUF_DEPTH + BRAM_LATENCY + 1);

  logic [XLEN-1:0]         pc_q, pc_d;
  logic [BRAM_LATENCY-1:0] valid_q, valid_d;
  logic [XLEN-1:0]         stage_pc_q [BRAM_LATENCY];
  logic [XLEN-1:0]         stage_pc_d [BRAM_LATENCY];

  logic [OCC_W-1:0] inflight_count;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] buf_count;
  logic             buf_empty;
  logic             issue;
  logic             resp_valid;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight_count = inflight_count + OCC_W'(valid_q[i]);
    end
  end

  // A pop in this cycle is deliberately not credited, so a push can never overflow.
  assign occupancy  = OCC_W'(buf_count) + inflight_count;
  assign issue      = !rst_in && !redirect_in && (occupancy < OCC_W'(BUF_DEPTH));
  assign resp_valid = !rst_in && !redirect_in && valid_q[BRAM_LATENCY-1];
  assign pop        = !rst_in && !redirect_in && !buf_empty && iq_ready_in;

  assign push_entry.pc    = stage_pc_q[BRAM_LATENCY-1];
  assign push_entry.instr = bram_data_in;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    stage_pc_d = stage_pc_q;
    for (int i = BRAM_LATENCY - 1; i >= 1; i--) begin
      valid_d[i]    = valid_q[i-1];
      stage_pc_d[i] = stage_pc_q[i-1];
    end
    valid_d[0]    = issue;
    stage_pc_d[0] = pc_q;
    if (redirect_in) begin
      pc_d    = redirect_pc_in;
      valid_d = '0;
    end else if (issue) begin
      pc_d = next_pc(pc_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        stage_pc_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      stage_pc_q <= stage_pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buffer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (redirect_in),
    .push_in      (resp_valid),
    .push_data_in (push_entry),
    .pop_in       (pop),
    .head_out     (head_entry),
    .count_out    (buf_count),
    .empty_out    (buf_empty)
  );

  assign bram_en_out     = issue;
  assign bram_addr_out   = pc_q;
  assign iq_valid_out    = !buf_empty;
  assign instruction_out = buf_empty ? '0 : head_entry.instr;
  assign pc_out          = buf_empty ? '0 : head_entry.pc;

endmodule
